modo2_gravador_controle: RTL and testbench

Control unit for FPGAudio mode 2 (record and playback). It records the notes the player presses into the shared note memory as {note code, duration in metronome ticks}, then replays them in order through the tone generator. It owns the memory address, write strobe and playback timing; the metronome and tone generator stay in the datapath.

---
 rtl/modo2_gravador_controle.sv | 277 +++++++++++++++++++++++++++
 tb/tb_modo2_gravador_controle.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modo2_gravador_controle.sv
// -----------------------------------------------------------------------------
// modo2_gravador_controle
// Control unit for FPGAudio mode 2 (record and playback).
// Recording stores each key press in the shared note memory as {code, dur},
// where dur is the number of metronome ticks the key was held.
// Playback reads the notes back in order and drives the tone generator.
//
// Ports:
//   clock            system clock, rising edge
//   reset            synchronous active-high reset, returns to OCIOSO
//   gravar           start recording (sampled only in OCIOSO)
//   reproduzir       start playback (sampled only in OCIOSO)
//   parar            stop the current recording or playback
//   tick             metronome pulse, one cycle wide
//   nota_ativa       a key is held
//   nota_codigo      code of the held key
//   mem_dado_lido    memory read data {code, dur}, 1-cycle read latency
//   mem_endereco     memory address
//   mem_dado_escrita memory write data {code, dur}
//   mem_we           memory write strobe, one cycle wide
//   toca             tone generator enable
//   nota_saida       note code for the tone generator (0 when silent)
//   gravando         high in the recording states
//   reproduzindo     high in the playback states
//   cheia            high while the memory holds 2^ADDR_W notes
//   fim_reproducao   one-cycle pulse when playback completes
//   n_notas          number of recorded notes
//   db_estado        current state encoding (debug)
// -----------------------------------------------------------------------------
module modo2_gravador_controle #(
    parameter int ADDR_W = 4,
    parameter int NOTE_W = 4,
    parameter int DUR_W  = 6
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      gravar,
    input  logic                      reproduzir,
    input  logic                      parar,
    input  logic                      tick,
    input  logic                      nota_ativa,
    input  logic [NOTE_W-1:0]         nota_codigo,
    input  logic [NOTE_W+DUR_W-1:0]   mem_dado_lido,
    output logic [ADDR_W-1:0]         mem_endereco,
    output logic [NOTE_W+DUR_W-1:0]   mem_dado_escrita,
    output logic                      mem_we,
    output logic                      toca,
    output logic [NOTE_W-1:0]         nota_saida,
    output logic                      gravando,
    output logic                      reproduzindo,
    output logic                      cheia,
    output logic                      fim_reproducao,
    output logic [ADDR_W:0]           n_notas,
    output logic [3:0]                db_estado
);

    localparam logic [3:0] OCIOSO    = 4'd0;
    localparam logic [3:0] G_ESPERA  = 4'd1;
    localparam logic [3:0] G_NOTA    = 4'd2;
    localparam logic [3:0] G_ESCREVE = 4'd3;
    localparam logic [3:0] R_LE      = 4'd4;
    localparam logic [3:0] R_CARREGA = 4'd5;
    localparam logic [3:0] R_TOCA    = 4'd6;
    localparam logic [3:0] R_PROX    = 4'd7;
    localparam logic [3:0] R_FIM     = 4'd8;

    localparam logic [ADDR_W:0]   N_ZERO     = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   N_UM       = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CAPACIDADE = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] END_ZERO   = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] END_UM     = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DUR_W-1:0]  DUR_ZERO   = {DUR_W{1'b0}};
    localparam logic [DUR_W-1:0]  DUR_UM     = {{(DUR_W-1){1'b0}}, 1'b1};
    localparam logic [DUR_W-1:0]  DUR_MAX    = {DUR_W{1'b1}};
    localparam logic [NOTE_W-1:0] COD_ZERO   = {NOTE_W{1'b0}};

    logic [3:0]        estado_r;
    logic [3:0]        estado_prox_s;
    logic [ADDR_W:0]   n_notas_r;
    logic [ADDR_W-1:0] endereco_r;
    logic [NOTE_W-1:0] codigo_r;
    logic [DUR_W-1:0]  dur_r;
    logic [DUR_W-1:0]  contador_r;
    logic              parar_visto_r;

    logic [DUR_W-1:0]  dur_gravada_s;
    logic              fim_nota_s;
    logic              ultima_nota_s;
    logic              enche_s;

    // A zero-tick press is stored as one tick so playback never gets dur = 0.
    assign dur_gravada_s = (dur_r == DUR_ZERO) ? DUR_UM : dur_r;
    // This tick completes the note; a dur of 0 read back from memory ends on the first tick.
    assign fim_nota_s    = ((contador_r + DUR_UM) == dur_r) || (dur_r == DUR_ZERO);
    // The note being left in R_PROX is the last recorded one.
    assign ultima_nota_s = (({1'b0, endereco_r}) + N_UM) == n_notas_r;
    // The write in progress fills the memory.
    assign enche_s       = (n_notas_r + N_UM) == CAPACIDADE;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_r <= OCIOSO;
        end else begin
            estado_r <= estado_prox_s;
        end
    end

    // Next-state logic.
    always_comb begin
        estado_prox_s = OCIOSO;
        case (estado_r)
            OCIOSO: begin
                if (gravar) begin
                    estado_prox_s = G_ESPERA;
                end else if (reproduzir) begin
                    estado_prox_s = (n_notas_r == N_ZERO) ? R_FIM : R_LE;
                end else begin
                    estado_prox_s = OCIOSO;
                end
            end
            G_ESPERA: begin
                if (parar) begin
                    estado_prox_s = OCIOSO;
                end else if (nota_ativa) begin
                    estado_prox_s = G_NOTA;
                end else begin
                    estado_prox_s = G_ESPERA;
                end
            end
            G_NOTA: begin
                if (parar || !nota_ativa) begin
                    estado_prox_s = G_ESCREVE;
                end else begin
                    estado_prox_s = G_NOTA;
                end
            end
            G_ESCREVE: begin
                if (parar_visto_r || enche_s) begin
                    estado_prox_s = OCIOSO;
                end else begin
                    estado_prox_s = G_ESPERA;
                end
            end
            R_LE: begin
                estado_prox_s = parar ? OCIOSO : R_CARREGA;
            end
            R_CARREGA: begin
                estado_prox_s = parar ? OCIOSO : R_TOCA;
            end
            R_TOCA: begin
                if (parar) begin
                    estado_prox_s = OCIOSO;
                end else if (tick && fim_nota_s) begin
                    estado_prox_s = R_PROX;
                end else begin
                    estado_prox_s = R_TOCA;
                end
            end
            R_PROX: begin
                if (parar) begin
                    estado_prox_s = OCIOSO;
                end else if (ultima_nota_s) begin
                    estado_prox_s = R_FIM;
                end else begin
                    estado_prox_s = R_LE;
                end
            end
            R_FIM: begin
                estado_prox_s = OCIOSO;
            end
            default: begin
                estado_prox_s = OCIOSO;
            end
        endcase
    end

    // Datapath registers: note count, playback address, latched note and tick counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            n_notas_r     <= N_ZERO;
            endereco_r    <= END_ZERO;
            codigo_r      <= COD_ZERO;
            dur_r         <= DUR_ZERO;
            contador_r    <= DUR_ZERO;
            parar_visto_r <= 1'b0;
        end else begin
            case (estado_r)
                OCIOSO: begin
                    if (gravar) begin
                        n_notas_r <= N_ZERO;
                    end else if (reproduzir) begin
                        endereco_r <= END_ZERO;
                    end
                end
                G_ESPERA: begin
                    if (!parar && nota_ativa) begin
                        codigo_r      <= nota_codigo;
                        dur_r         <= DUR_ZERO;
                        parar_visto_r <= 1'b0;
                    end
                end
                G_NOTA: begin
                    if (parar) begin
                        parar_visto_r <= 1'b1;
                    end
                    // A tick coinciding with the release is not counted.
                    if (tick && nota_ativa && (dur_r != DUR_MAX)) begin
                        dur_r <= dur_r + DUR_UM;
                    end
                end
                G_ESCREVE: begin
                    n_notas_r <= n_notas_r + N_UM;
                end
                R_CARREGA: begin
                    codigo_r   <= mem_dado_lido[NOTE_W+DUR_W-1:DUR_W];
                    dur_r      <= mem_dado_lido[DUR_W-1:0];
                    contador_r <= DUR_ZERO;
                end
                R_TOCA: begin
                    if (tick) begin
                        contador_r <= contador_r + DUR_UM;
                    end
                end
                R_PROX: begin
                    endereco_r <= endereco_r + END_UM;
                end
                default: begin
                end
            endcase
        end
    end

    // Moore output decode from the state and datapath registers.
    always_comb begin
        mem_endereco     = endereco_r;
        mem_dado_escrita = {NOTE_W+DUR_W{1'b0}};
        mem_we           = 1'b0;
        toca             = 1'b0;
        nota_saida       = COD_ZERO;
        gravando         = 1'b0;
        reproduzindo     = 1'b0;
        fim_reproducao   = 1'b0;
        case (estado_r)
            G_ESPERA, G_NOTA: begin
                gravando     = 1'b1;
                mem_endereco = n_notas_r[ADDR_W-1:0];
            end
            G_ESCREVE: begin
                gravando         = 1'b1;
                mem_endereco     = n_notas_r[ADDR_W-1:0];
                mem_dado_escrita = {codigo_r, dur_gravada_s};
                mem_we           = 1'b1;
            end
            R_LE, R_CARREGA, R_PROX: begin
                reproduzindo = 1'b1;
            end
            R_TOCA: begin
                reproduzindo = 1'b1;
                toca         = 1'b1;
                nota_saida   = codigo_r;
            end
            R_FIM: begin
                reproduzindo   = 1'b1;
                fim_reproducao = 1'b1;
            end
            default: begin
                mem_endereco = endereco_r;
            end
        endcase
    end

    assign cheia     = (n_notas_r == CAPACIDADE);
    assign n_notas   = n_notas_r;
    assign db_estado = estado_r;

endmodule

// File: tb/tb_modo2_gravador_controle.sv
// -----------------------------------------------------------------------------
// Testbench for modo2_gravador_controle: a cycle-by-cycle vector table for a
// three-note recording and its playback, followed by hand-written sequences
// for stop, full memory, duration saturation and reset corner cases.
// A small synchronous memory model stands in for the shared note memory.
// -----------------------------------------------------------------------------
module tb_modo2_gravador_controle;

    localparam int ADDR_W = 4;
    localparam int NOTE_W = 4;
    localparam int DUR_W  = 6;

    logic                    clock;
    logic                    reset;
    logic                    gravar;
    logic                    reproduzir;
    logic                    parar;
    logic                    tick;
    logic                    nota_ativa;
    logic [NOTE_W-1:0]       nota_codigo;
    logic [NOTE_W+DUR_W-1:0] mem_dado_lido;
    logic [ADDR_W-1:0]       mem_endereco;
    logic [NOTE_W+DUR_W-1:0] mem_dado_escrita;
    logic                    mem_we;
    logic                    toca;
    logic [NOTE_W-1:0]       nota_saida;
    logic                    gravando;
    logic                    reproduzindo;
    logic                    cheia;
    logic                    fim_reproducao;
    logic [ADDR_W:0]         n_notas;
    logic [3:0]              db_estado;

    logic [NOTE_W+DUR_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_cmp = 0;
    int n_err = 0;

    modo2_gravador_controle #(
        .ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .gravar          (gravar),
        .reproduzir      (reproduzir),
        .parar           (parar),
        .tick            (tick),
        .nota_ativa      (nota_ativa),
        .nota_codigo     (nota_codigo),
        .mem_dado_lido   (mem_dado_lido),
        .mem_endereco    (mem_endereco),
        .mem_dado_escrita(mem_dado_escrita),
        .mem_we          (mem_we),
        .toca            (toca),
        .nota_saida      (nota_saida),
        .gravando        (gravando),
        .reproduzindo    (reproduzindo),
        .cheia           (cheia),
        .fim_reproducao  (fim_reproducao),
        .n_notas         (n_notas),
        .db_estado       (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Note memory model: synchronous write and synchronous read.
    always @(posedge clock) begin
        if (mem_we) begin
            mem[mem_endereco] <= mem_dado_escrita;
        end
        mem_dado_lido <= mem[mem_endereco];
    end

    typedef struct {
        int g, r, p, t, a, cod;          // inputs
        int est, we, ca, addr, dado, n;  // expected state / memory side
        int toca, nota, fim;             // expected playback side
    } vec_t;

    vec_t rec_tab[$];
    vec_t play_tab[$];

    function automatic vec_t v(input int g, r, p, t, a, cod,
                               input int est, we, ca, addr, dado, n,
                               input int tc, nota, fim);
        vec_t x;
        x.g = g; x.r = r; x.p = p; x.t = t; x.a = a; x.cod = cod;
        x.est = est; x.we = we; x.ca = ca; x.addr = addr; x.dado = dado; x.n = n;
        x.toca = tc; x.nota = nota; x.fim = fim;
        return x;
    endfunction

    task automatic chk(input string nome, input int atual, input int esperado);
        n_cmp++;
        if (atual != esperado) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nome, atual, esperado);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        gravar = 1'b0; reproduzir = 1'b0; parar = 1'b0; tick = 1'b0;
        nota_ativa = 1'b0; nota_codigo = 4'd0;
    endtask

    task automatic apply_vec(input string tab, input int i, input vec_t x);
        gravar      = x.g[0];
        reproduzir  = x.r[0];
        parar       = x.p[0];
        tick        = x.t[0];
        nota_ativa  = x.a[0];
        nota_codigo = x.cod[NOTE_W-1:0];
        step();
        chk($sformatf("%s[%0d] estado", tab, i), int'(db_estado), x.est);
        chk($sformatf("%s[%0d] mem_we", tab, i), int'(mem_we), x.we);
        chk($sformatf("%s[%0d] n_notas", tab, i), int'(n_notas), x.n);
        chk($sformatf("%s[%0d] toca", tab, i), int'(toca), x.toca);
        chk($sformatf("%s[%0d] nota_saida", tab, i), int'(nota_saida), x.nota);
        chk($sformatf("%s[%0d] fim", tab, i), int'(fim_reproducao), x.fim);
        chk($sformatf("%s[%0d] gravando", tab, i), int'(gravando),
            (x.est >= 1 && x.est <= 3) ? 1 : 0);
        chk($sformatf("%s[%0d] reproduzindo", tab, i), int'(reproduzindo),
            (x.est >= 4 && x.est <= 8) ? 1 : 0);
        if (x.ca != 0) begin
            chk($sformatf("%s[%0d] endereco", tab, i), int'(mem_endereco), x.addr);
        end
        if (x.we != 0) begin
            chk($sformatf("%s[%0d] dado_escrita", tab, i), int'(mem_dado_escrita), x.dado);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;

        // Record code 3 for 2 ticks, code 5 for 4 ticks, code 1 for 1 tick, then stop.
        //                    g r p t a cod   est we ca addr dado n  toca nota fim
        rec_tab.push_back(v(1,0,0,0,0,0,     1, 0, 0, 0,   0,  0, 0, 0, 0));
        rec_tab.push_back(v(0,0,0,0,1,3,     2, 0, 0, 0,   0,  0, 0, 0, 0));
        rec_tab.push_back(v(0,0,0,1,1,3,     2, 0, 0, 0,   0,  0, 0, 0, 0));
        rec_tab.push_back(v(1,1,0,0,1,7,     2, 0, 0, 0,   0,  0, 0, 0, 0));
        rec_tab.push_back(v(0,0,0,1,1,7,     2, 0, 0, 0,   0,  0, 0, 0, 0));
        rec_tab.push_back(v(0,0,0,1,0,0,     3, 1, 1, 0, 194,  0, 0, 0, 0));
        rec_tab.push_back(v(0,0,0,0,0,0,     1, 0, 0, 0,   0,  1, 0, 0, 0));
        rec_tab.push_back(v(0,0,0,0,1,5,     2, 0, 0, 0,   0,  1, 0, 0, 0));
        for (int k = 0; k < 4; k++) begin
            rec_tab.push_back(v(0,0,0,1,1,5, 2, 0, 0, 0,   0,  1, 0, 0, 0));
        end
        rec_tab.push_back(v(0,0,0,0,0,0,     3, 1, 1, 1, 324,  1, 0, 0, 0));
        rec_tab.push_back(v(0,0,0,0,0,0,     1, 0, 0, 0,   0,  2, 0, 0, 0));
        rec_tab.push_back(v(0,0,0,0,1,1,     2, 0, 0, 0,   0,  2, 0, 0, 0));
        rec_tab.push_back(v(0,0,0,1,1,1,     2, 0, 0, 0,   0,  2, 0, 0, 0));
        rec_tab.push_back(v(0,0,0,0,0,0,     3, 1, 1, 2,  65,  2, 0, 0, 0));
        rec_tab.push_back(v(0,0,0,0,0,0,     1, 0, 0, 0,   0,  3, 0, 0, 0));
        rec_tab.push_back(v(0,0,1,0,0,0,     0, 0, 0, 0,   0,  3, 0, 0, 0));

        // Play the recording back.
        play_tab.push_back(v(0,1,0,0,0,0,    4, 0, 1, 0,   0,  3, 0, 0, 0));
        play_tab.push_back(v(0,0,0,0,0,0,    5, 0, 0, 0,   0,  3, 0, 0, 0));
        play_tab.push_back(v(0,0,0,0,0,0,    6, 0, 0, 0,   0,  3, 1, 3, 0));
        play_tab.push_back(v(0,0,0,1,0,0,    6, 0, 0, 0,   0,  3, 1, 3, 0));
        play_tab.push_back(v(0,0,0,0,0,0,    6, 0, 0, 0,   0,  3, 1, 3, 0));
        play_tab.push_back(v(0,0,0,1,0,0,    7, 0, 0, 0,   0,  3, 0, 0, 0));
        play_tab.push_back(v(0,0,0,0,0,0,    4, 0, 1, 1,   0,  3, 0, 0, 0));
        play_tab.push_back(v(0,0,0,0,0,0,    5, 0, 0, 0,   0,  3, 0, 0, 0));
        play_tab.push_back(v(0,0,0,0,0,0,    6, 0, 0, 0,   0,  3, 1, 5, 0));
        for (int k = 0; k < 3; k++) begin
            play_tab.push_back(v(0,0,0,1,0,0, 6, 0, 0, 0,  0,  3, 1, 5, 0));
        end
        play_tab.push_back(v(0,0,0,1,0,0,    7, 0, 0, 0,   0,  3, 0, 0, 0));
        play_tab.push_back(v(0,0,0,0,0,0,    4, 0, 1, 2,   0,  3, 0, 0, 0));
        play_tab.push_back(v(0,0,0,0,0,0,    5, 0, 0, 0,   0,  3, 0, 0, 0));
        play_tab.push_back(v(0,0,0,0,0,0,    6, 0, 0, 0,   0,  3, 1, 1, 0));
        play_tab.push_back(v(0,0,0,1,0,0,    7, 0, 0, 0,   0,  3, 0, 0, 0));
        play_tab.push_back(v(0,0,0,0,0,0,    8, 0, 0, 0,   0,  3, 0, 0, 1));
        play_tab.push_back(v(0,0,0,0,0,0,    0, 0, 0, 0,   0,  3, 0, 0, 0));

        // Reset state.
        step();
        step();
        reset = 1'b0;
        chk("reset estado", int'(db_estado), 0);
        chk("reset n_notas", int'(n_notas), 0);
        chk("reset outs", int'({mem_we, toca, gravando, reproduzindo, cheia, fim_reproducao}), 0);
        chk("reset nota_saida", int'(nota_saida), 0);
        chk("reset dado_escrita", int'(mem_dado_escrita), 0);
        chk("reset endereco", int'(mem_endereco), 0);

        foreach (rec_tab[i]) apply_vec("rec", i, rec_tab[i]);
        foreach (play_tab[i]) apply_vec("play", i, play_tab[i]);
        idle_inputs();

        // Stop during note 2 of playback.
        reproduzir = 1'b1; step(); reproduzir = 1'b0;
        step(); step();                       // R_CARREGA, R_TOCA note 3
        tick = 1'b1; step(); step(); tick = 1'b0;   // two ticks -> R_PROX
        step(); step(); step();               // R_LE, R_CARREGA, R_TOCA note 5
        chk("stop toca before", int'(toca), 1);
        chk("stop nota before", int'(nota_saida), 5);
        tick = 1'b1; step(); tick = 1'b0;
        parar = 1'b1; step(); parar = 1'b0;
        chk("stop toca", int'(toca), 0);
        chk("stop estado", int'(db_estado), 0);
        chk("stop fim", int'(fim_reproducao), 0);
        chk("stop reproduzindo", int'(reproduzindo), 0);
        step();
        chk("stop fim later", int'(fim_reproducao), 0);

        // gravar, reproduzir and parar together: gravar wins.
        gravar = 1'b1; reproduzir = 1'b1; parar = 1'b1; step();
        idle_inputs();
        chk("simult estado", int'(db_estado), 1);
        chk("simult n_notas", int'(n_notas), 0);
        // parar and nota_ativa together in G_ESPERA: parar wins, no write.
        parar = 1'b1; nota_ativa = 1'b1; nota_codigo = 4'd6; step();
        idle_inputs();
        chk("pararnota estado", int'(db_estado), 0);
        chk("pararnota we", int'(mem_we), 0);
        step();
        chk("pararnota we later", int'(mem_we), 0);
        chk("pararnota n_notas", int'(n_notas), 0);

        // Fill the memory with 16 zero-tick notes.
        gravar = 1'b1; step(); gravar = 1'b0;
        for (int i = 0; i < 16; i++) begin
            nota_ativa = 1'b1; nota_codigo = 4'(i); step();
            nota_ativa = 1'b0; step();
            chk($sformatf("full[%0d] we", i), int'(mem_we), 1);
            chk($sformatf("full[%0d] endereco", i), int'(mem_endereco), i);
            chk($sformatf("full[%0d] dado", i), int'(mem_dado_escrita), i * 64 + 1);
            step();
            chk($sformatf("full[%0d] n_notas", i), int'(n_notas), i + 1);
            chk($sformatf("full[%0d] cheia", i), int'(cheia), (i == 15) ? 1 : 0);
            chk($sformatf("full[%0d] estado", i), int'(db_estado), (i == 15) ? 0 : 1);
        end
        nota_ativa = 1'b1; nota_codigo = 4'd4;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("full extra[%0d] we", k), int'(mem_we), 0);
        end
        nota_ativa = 1'b0;
        chk("full extra n_notas", int'(n_notas), 16);

        // Hold a key for 70 ticks: duration saturates at 63.
        gravar = 1'b1; step(); gravar = 1'b0;
        chk("sat n_notas clear", int'(n_notas), 0);
        chk("sat cheia clear", int'(cheia), 0);
        nota_ativa = 1'b1; nota_codigo = 4'd9; step();
        for (int k = 0; k < 70; k++) begin
            tick = 1'b1; step();
            tick = 1'b0; step();
        end
        nota_ativa = 1'b0; step();
        chk("sat we", int'(mem_we), 1);
        chk("sat endereco", int'(mem_endereco), 0);
        chk("sat dado", int'(mem_dado_escrita), 9 * 64 + 63);
        step();
        chk("sat estado", int'(db_estado), 1);
        parar = 1'b1; step(); parar = 1'b0;
        chk("sat n_notas", int'(n_notas), 1);

        // Reset in G_NOTA, then playback of an empty recording.
        gravar = 1'b1; step(); gravar = 1'b0;
        nota_ativa = 1'b1; nota_codigo = 4'd2; step();
        tick = 1'b1; step(); tick = 1'b0;
        chk("rst pre estado", int'(db_estado), 2);
        reset = 1'b1; step(); reset = 1'b0;
        nota_ativa = 1'b0;
        chk("rst estado", int'(db_estado), 0);
        chk("rst n_notas", int'(n_notas), 0);
        chk("rst outs", int'({mem_we, toca, gravando, reproduzindo, cheia, fim_reproducao}), 0);
        chk("rst nota_saida", int'(nota_saida), 0);
        chk("rst dado_escrita", int'(mem_dado_escrita), 0);
        chk("rst endereco", int'(mem_endereco), 0);
        reproduzir = 1'b1; step(); reproduzir = 1'b0;
        chk("empty estado", int'(db_estado), 8);
        chk("empty fim", int'(fim_reproducao), 1);
        chk("empty toca", int'(toca), 0);
        step();
        chk("empty fim drop", int'(fim_reproducao), 0);
        chk("empty estado end", int'(db_estado), 0);
        chk("empty toca end", int'(toca), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
